// File: rtl/fsm_rd_094_mon.sv
// rtl/fsm_rd_094_mon.sv - receive-side monitor for the fsm_rd_094 rtext response frame
module fsm_rd_094_mon #(
   parameter int CNT_W   = 8,
   parameter int MIN_GAP = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [2:0]       rtext,
   input  logic             clr,
   output logic             trig,
   output logic             frame_ok,
   output logic             frame_err,
   output logic [1:0]       err_code,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   // Gap counter only needs to reach MIN_GAP; one spare bit keeps MIN_GAP=0 legal.
   localparam int GW = $clog2(MIN_GAP + 1) + 1;
   localparam logic [GW-1:0]    GAP_MAX = GW'(MIN_GAP);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   localparam logic [2:0] SYM_IDLE  = 3'b000;
   localparam logic [2:0] SYM_START = 3'b010;
   localparam logic [2:0] SYM_END   = 3'b100;

   localparam logic [1:0] ERR_FRAME = 2'b01;
   localparam logic [1:0] ERR_GAP   = 2'b11;
   localparam logic [1:0] ERR_IDLE  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_F1   = 3'd1,
      S_F2   = 3'd2,
      S_F3   = 3'd3,
      S_F4   = 3'd4
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [GW-1:0]   gap_q;
   logic [GW-1:0]   gap_d;
   logic            trig_d;
   logic            ok_d;
   logic            err_d;
   logic [1:0]      code_d;
   logic            mism;
   logic [CNT_W-1:0] frame_cnt_d;
   logic [CNT_W-1:0] err_cnt_d;

   // Next-state, gap tracking and one-cycle event decode for the sampled symbol.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      trig_d  = 1'b0;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      code_d  = err_code;
      mism    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rtext == SYM_IDLE) begin
               if (gap_q < GAP_MAX) begin
                  gap_d = GW'(gap_q + 1'b1);
               end
            end else if (rtext == SYM_START) begin
               state_d = S_F1;
               trig_d  = 1'b1;
               // A short gap is reported but the frame is still tracked.
               if (gap_q < GAP_MAX) begin
                  err_d  = 1'b1;
                  code_d = ERR_GAP;
               end
            end else begin
               err_d  = 1'b1;
               code_d = ERR_IDLE;
            end
         end
         S_F1: begin
            if (rtext == SYM_IDLE) state_d = S_F2;
            else                   mism    = 1'b1;
         end
         S_F2: begin
            if (rtext == SYM_IDLE) state_d = S_F3;
            else                   mism    = 1'b1;
         end
         S_F3: begin
            if (rtext == SYM_END) state_d = S_F4;
            else                  mism    = 1'b1;
         end
         S_F4: begin
            if (rtext == SYM_END) begin
               state_d = S_IDLE;
               ok_d    = 1'b1;
               gap_d   = '0;
            end else begin
               mism = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            gap_d   = GAP_MAX;
         end
      endcase

      // In-frame mismatch has top priority and resyncs at once; a 010 here
      // is taken as the start of the next frame.
      if (mism) begin
         err_d  = 1'b1;
         code_d = ERR_FRAME;
         gap_d  = GAP_MAX;
         if (rtext == SYM_START) begin
            state_d = S_F1;
            trig_d  = 1'b1;
         end else begin
            state_d = S_IDLE;
         end
      end
   end

   // Saturating counter updates; clr overrides any increment in the same cycle.
   always_comb begin
      frame_cnt_d = frame_cnt;
      err_cnt_d   = err_cnt;
      if (clr) begin
         frame_cnt_d = '0;
         err_cnt_d   = '0;
      end else begin
         if (ok_d && (frame_cnt != CNT_MAX)) begin
            frame_cnt_d = frame_cnt + 1'b1;
         end
         if (err_d && (err_cnt != CNT_MAX)) begin
            err_cnt_d = err_cnt + 1'b1;
         end
      end
   end

   // State and gap registers; reset leaves the gap satisfied so the first frame is clean.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
         gap_q   <= GAP_MAX;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
      end
   end

   // Registered event pulses, held error code and busy flag.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         trig      <= 1'b0;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= 2'b00;
         busy      <= 1'b0;
      end else begin
         trig      <= trig_d;
         frame_ok  <= ok_d;
         frame_err <= err_d;
         err_code  <= code_d;
         busy      <= (state_d != S_IDLE);
      end
   end

   // Frame and error counters.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         frame_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         frame_cnt <= frame_cnt_d;
         err_cnt   <= err_cnt_d;
      end
   end

endmodule
